// File: rtl/conf_pkt_loader.sv
// conf_pkt_loader: streams firmware words from memory as write packets, then sends the boot start packet
module conf_pkt_loader #(
   parameter int MEM_WORDS   = 16384,
   parameter int BURST_WORDS = 64
) (
   input  logic         i_pe_clk,
   input  logic         i_rst,
   input  logic         i_start,
   output logic         o_mem_rden,
   output logic [15:0]  o_mem_addr,
   input  logic [31:0]  i_mem_rdata,
   output logic         o_data_valid,
   output logic [133:0] o_data,
   input  logic         i_alf,
   output logic         o_busy,
   output logic         o_done
);
   localparam logic [133:0] META_BEAT  = {2'b11, 4'hf, 96'b0, 4'h1, 12'h0, 16'b0};
   localparam logic [133:0] HDR_BEAT   = {2'b01, 4'hf, 48'h8988, 48'h1111, 16'h9005, 16'h3};
   localparam logic [133:0] S_HDR_BEAT = {2'b01, 4'hf, 48'h8988, 48'h1111, 16'h9005, 16'h1};
   localparam logic [133:0] TAIL_BEAT  = {2'b10, 4'hf, 96'b0, 16'hfe, 16'b0};
   localparam logic [16:0]  LAST_BEAT  = 17'(BURST_WORDS - 1);
   localparam logic [16:0]  LAST_WORD  = 17'(MEM_WORDS - 1);

   typedef enum logic [3:0] {IDLE, WAIT_ALF, META, HDR, DATA, S_WAIT, S_META, S_HDR, S_TAIL} stateT;

   stateT        state;
   logic [15:0]  wcnt;
   logic [16:0]  kCnt;
   logic [133:0] beatReg;
   logic         inData;
   logic [16:0]  nextK;
   logic         nextLast;

   // Data beats carry everything but the read data in registers; the word itself arrives one cycle after the read
   function automatic logic [133:0] dataBeat(input logic last, input logic [15:0] addr);
      return {last ? 2'b10 : 2'b00, 4'hf, 48'b0, 32'b0, 16'b0, addr, 16'b0};
   endfunction

   assign nextK    = (state == HDR) ? 17'd0 : kCnt + 17'd1;
   assign nextLast = (nextK == LAST_BEAT);
   assign o_data   = beatReg | {54'b0, inData ? i_mem_rdata : 32'b0, 48'b0};

   // Sequencer: every output register is loaded with the value for the state being entered
   always_ff @(posedge i_pe_clk or posedge i_rst) begin
      if (i_rst) begin
         state        <= IDLE;
         wcnt         <= '0;
         kCnt         <= '0;
         beatReg      <= '0;
         inData       <= 1'b0;
         o_data_valid <= 1'b0;
         o_mem_rden   <= 1'b0;
         o_mem_addr   <= '0;
         o_busy       <= 1'b0;
         o_done       <= 1'b0;
      end else begin
         o_done <= 1'b0;
         case (state)
            IDLE: if (i_start) begin
               o_busy <= 1'b1;
               wcnt   <= '0;
               state  <= WAIT_ALF;
            end
            WAIT_ALF, S_WAIT: if (!i_alf) begin
               o_data_valid <= 1'b1;
               beatReg      <= META_BEAT;
               state        <= (state == WAIT_ALF) ? META : S_META;
            end
            META: begin
               beatReg    <= HDR_BEAT;
               o_mem_rden <= 1'b1;
               o_mem_addr <= wcnt;
               state      <= HDR;
            end
            HDR, DATA: if (state == HDR || kCnt != LAST_BEAT) begin
               beatReg    <= dataBeat(nextLast, o_mem_addr);
               inData     <= 1'b1;
               kCnt       <= nextK;
               o_mem_rden <= !nextLast;
               o_mem_addr <= nextLast ? 16'd0 : wcnt + 16'd1;
               wcnt       <= nextLast ? wcnt : wcnt + 16'd1;
               state      <= DATA;
            end else begin
               beatReg      <= '0;
               inData       <= 1'b0;
               o_data_valid <= 1'b0;
               wcnt         <= ({1'b0, wcnt} == LAST_WORD) ? wcnt : wcnt + 16'd1;
               state        <= ({1'b0, wcnt} == LAST_WORD) ? S_WAIT : WAIT_ALF;
            end
            S_META: begin
               beatReg <= S_HDR_BEAT;
               state   <= S_HDR;
            end
            S_HDR: begin
               beatReg <= TAIL_BEAT;
               state   <= S_TAIL;
            end
            S_TAIL: begin
               beatReg      <= '0;
               o_data_valid <= 1'b0;
               o_busy       <= 1'b0;
               o_done       <= 1'b1;
               state        <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
